// File: rtl/az_sequencer_if.sv
// az_sequencer_if: configuration, ADC handshake and switch-control bundle of the auto-zero sequencer.
interface az_sequencer_if #(
    parameter int CNT_W  = 24,
    parameter int SCNT_W = 16
);
    logic              enable;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  settle_cnt;
    logic [CNT_W-1:0]  aperture_cnt;
    logic [2:0]        az_sig_val;
    logic [2:0]        az_lo_val;
    logic              adc_ready;
    logic              sw_pc_ctl;
    logic [2:0]        mux_az;
    logic              adc_meas;
    logic              sample_valid;
    logic              sample_phase;
    logic [SCNT_W-1:0] sample_cnt;
    logic              busy;

    modport master (
        input  enable, mode, settle_cnt, aperture_cnt, az_sig_val, az_lo_val, adc_ready,
        output sw_pc_ctl, mux_az, adc_meas, sample_valid, sample_phase, sample_cnt, busy
    );

    modport slave (
        output enable, mode, settle_cnt, aperture_cnt, az_sig_val, az_lo_val, adc_ready,
        input  sw_pc_ctl, mux_az, adc_meas, sample_valid, sample_phase, sample_cnt, busy
    );
endinterface

// File: rtl/az_sequencer.sv
// az_sequencer: auto-zero LO/SIG sequencer driving the AZ mux, precharge switch and ADC aperture.
module az_sequencer #(
    parameter int CNT_W  = 24,
    parameter int SCNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    az_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, APERTURE, WAIT_ADC} state_t;

    state_t            state, state_n;
    logic [1:0]        mode_q, mode_n;
    logic [CNT_W-1:0]  settle_q, settle_n, aper_q, aper_n, cnt, cnt_n;
    logic [2:0]        sig_q, sig_n, lo_q, lo_n, mux_n;
    logic              phase, phase_n, pc_n, meas_n, valid_n, sphase_n;
    logic [SCNT_W-1:0] scnt_n;

    // Zero counts behave as one cycle: the counter is loaded with max(v,1)-1.
    function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        settle_n = settle_q;
        aper_n   = aper_q;
        sig_n    = sig_q;
        lo_n     = lo_q;
        cnt_n    = cnt;
        phase_n  = phase;
        pc_n     = bus.sw_pc_ctl;
        mux_n    = bus.mux_az;
        meas_n   = bus.adc_meas;
        valid_n  = 1'b0;
        sphase_n = bus.sample_phase;
        scnt_n   = bus.sample_cnt;
        if (state != IDLE && !bus.enable) begin
            state_n = IDLE;
            pc_n    = 1'b0;
            mux_n   = 3'b000;
            meas_n  = 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.enable && bus.mode != 2'd0) begin
                    state_n  = SETTLE;
                    mode_n   = bus.mode;
                    settle_n = bus.settle_cnt;
                    aper_n   = bus.aperture_cnt;
                    sig_n    = bus.az_sig_val;
                    lo_n     = bus.az_lo_val;
                    phase_n  = bus.mode == 2'd2;
                    cnt_n    = ld(bus.settle_cnt);
                    pc_n     = phase_n;
                    mux_n    = phase_n ? bus.az_sig_val : bus.az_lo_val;
                    scnt_n   = '0;
                end
                SETTLE: if (cnt == '0) begin
                    state_n = APERTURE;
                    cnt_n   = ld(aper_q);
                    meas_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
                APERTURE: if (cnt == '0) begin
                    state_n = WAIT_ADC;
                    meas_n  = 1'b0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
                WAIT_ADC: if (bus.adc_ready) begin
                    valid_n  = 1'b1;
                    sphase_n = phase;
                    scnt_n   = bus.sample_cnt + SCNT_W'(1);
                    if (mode_q == 2'd1) begin
                        state_n = SETTLE;
                        phase_n = !phase;
                        cnt_n   = ld(settle_q);
                        pc_n    = !phase;
                        mux_n   = phase ? lo_q : sig_q;
                    end else begin
                        state_n = APERTURE;
                        cnt_n   = ld(aper_q);
                        meas_n  = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            mode_q           <= 2'd0;
            settle_q         <= '0;
            aper_q           <= '0;
            sig_q            <= 3'b000;
            lo_q             <= 3'b000;
            cnt              <= '0;
            phase            <= 1'b0;
            bus.sw_pc_ctl    <= 1'b0;
            bus.mux_az       <= 3'b000;
            bus.adc_meas     <= 1'b0;
            bus.sample_valid <= 1'b0;
            bus.sample_phase <= 1'b0;
            bus.sample_cnt   <= '0;
            bus.busy         <= 1'b0;
        end else begin
            state            <= state_n;
            mode_q           <= mode_n;
            settle_q         <= settle_n;
            aper_q           <= aper_n;
            sig_q            <= sig_n;
            lo_q             <= lo_n;
            cnt              <= cnt_n;
            phase            <= phase_n;
            bus.sw_pc_ctl    <= pc_n;
            bus.mux_az       <= mux_n;
            bus.adc_meas     <= meas_n;
            bus.sample_valid <= valid_n;
            bus.sample_phase <= sphase_n;
            bus.sample_cnt   <= scnt_n;
            bus.busy         <= state_n != IDLE;
        end
    end
endmodule

// File: doc/az_sequencer.md
# az_sequencer

Autonomous auto-zero measurement sequencer for the DMM front end. It drives the precharge switch and the AZ mux, and opens the ADC integration aperture. In AZ mode it alternates LO (zero) and SIG phases, with a settle interval after each switch change. The block sits between the SPI register bank (configuration) and the analog switch control pins / ADC controller, and replaces hard-coded test patterns driving the AZ mux.

## Interface
Parameters:
- CNT_W, default 24: width of the settle/aperture counters and their config inputs.
- SCNT_W, default 16: width of the completed-sample counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low; forces all state and outputs to reset values.
- enable  in  1  run request; level-sensitive.
- mode  in  2  0 = off, 1 = AZ (alternate LO/SIG), 2 = SIG only, 3 = LO only.
- settle_cnt  in  CNT_W  clocks to wait after a switch change.
- aperture_cnt  in  CNT_W  integration length in clocks.
- az_sig_val  in  3  mux_az code for the SIG phase.
- az_lo_val  in  3  mux_az code for the LO phase.
- adc_ready  in  1  ADC has finished conversion/readout of the last aperture.
- sw_pc_ctl  out  1  precharge/signal switch; 1 = signal path.
- mux_az  out  3  AZ mux address.
- adc_meas  out  1  integration aperture; high while integrating.
- sample_valid  out  1  one-cycle pulse per completed sample.
- sample_phase  out  1  phase of the completed sample (0 = LO, 1 = SIG); valid with sample_valid.
- sample_cnt  out  SCNT_W  completed samples since the run started.
- busy  out  1  high whenever the block is not in IDLE.

## Operation
- States: IDLE, SETTLE, APERTURE, WAIT_ADC. All outputs are registered.
- IDLE:
  - sw_pc_ctl = 0, mux_az = 3'b000, adc_meas = 0, busy = 0.
  - Leave IDLE when enable = 1 and mode != 0.
- On leaving IDLE:
  - Latch mode, settle_cnt, aperture_cnt, az_sig_val and az_lo_val.
  - Changes to these inputs during a run are ignored until the next IDLE exit.
  - Clear sample_cnt to 0.
  - Starting phase: LO for modes 1 and 3, SIG for mode 2.
- SETTLE:
  - mux_az = latched code of the current phase (az_lo_val or az_sig_val); sw_pc_ctl = 1 only in the SIG phase.
  - Stays for max(settle_cnt, 1) cycles, then moves to APERTURE.
- APERTURE:
  - adc_meas = 1 for exactly max(aperture_cnt, 1) cycles; mux_az and sw_pc_ctl unchanged.
  - Then moves to WAIT_ADC.
- WAIT_ADC:
  - adc_meas = 0; waits for adc_ready = 1.
  - On the cycle after adc_ready is sampled high: sample_valid = 1, sample_phase = current phase, sample_cnt increments (wraps all-ones -> 0).
  - Next state:
    - Mode 1: toggle phase, then SETTLE.
    - Modes 2/3: go directly to APERTURE. No settle, because the switches do not change.
- enable = 0 in any non-IDLE state forces IDLE on the next edge:
  - Outputs take IDLE values and no sample_valid is issued.
  - sample_cnt holds its value.
- Simultaneous enable drop and adc_ready: the enable drop wins; no sample_valid.

## Timing
- Reset values: sw_pc_ctl 0, mux_az 0, adc_meas 0, sample_valid 0, sample_phase 0, sample_cnt 0, busy 0. State = IDLE.
- Start latency: enable sampled high at edge N -> busy = 1 and mux_az = phase code from edge N+1.
- SETTLE occupies edges N+1 .. N+S, where S = max(settle_cnt, 1). adc_meas rises at edge N+S+1.
- adc_meas high width = max(aperture_cnt, 1) cycles exactly.
- adc_ready sampled high at edge M in WAIT_ADC -> sample_valid high for the single cycle after edge M+1.
- The phase change is registered at the same edge M+1.
- adc_ready already high on WAIT_ADC entry: WAIT_ADC lasts 1 cycle.
- mux_az and sw_pc_ctl never change while adc_meas = 1.
- Reset mid-run: asynchronous return to reset values, independent of clk.

## Test plan
- Reset: assert reset mid-APERTURE -> adc_meas, mux_az, busy and sample_cnt go to 0 immediately, without a clock edge.
- AZ run: mode 1, settle 3, aperture 5, az_lo 3'b011, az_sig 3'b110, adc_ready tied 1.
  - Required sequence: mux_az 3 for 3 cycles, adc_meas high 5 cycles, sample_valid with phase 0; then mux_az 6 with sw_pc_ctl 1, repeat with phase 1.
  - sample_cnt = 4 after two full LO/SIG pairs.
- SIG-only: mode 2, settle 10, aperture 4 -> one settle only. Back-to-back apertures are separated only by WAIT_ADC; sw_pc_ctl stays 1 and every sample_phase is 1.
- Zero counts: settle 0, aperture 0 -> each behaves as 1 cycle; adc_meas pulse width is 1.
- Handshake: hold adc_ready low for 20 cycles after an aperture -> block stays in WAIT_ADC with no sample_valid. Raise adc_ready -> exactly one sample_valid.
- Abort and wrap:
  - Drop enable on the same cycle adc_ready rises -> IDLE, no sample_valid, sample_cnt unchanged.
  - With SCNT_W = 4, 17 samples -> sample_cnt = 1.
